button_conditioner: RTL
=======================

# button_conditioner

Clocked front-end for the board push-buttons that drive the angle-control stages (theta/phi step and reset inputs). Synchronizes raw active-low keys to `CLK`, debounces them, and emits clean single-cycle step events, with optional auto-repeat while a key is held. Its `o_step_n` outputs connect directly to the negedge-sensitive step/reset inputs of the angle-control block, giving exactly one falling edge per press or repeat.

## Interface
Parameters:
- `N_BTN`, 3: number of independent button channels.
- `DEBOUNCE_CYC`, 500000: consecutive stable cycles required to accept a level change (10 ms at 50 MHz); >= 1.
- `REPEAT_DELAY_CYC`, 25000000: cycles from accepted press to first repeat event; >= 1.
- `REPEAT_RATE_CYC`, 5000000: cycles between subsequent repeat events; >= 1.
- `CNT_W`, 26: width of per-channel counters; must hold the largest of the three cycle parameters.

Ports:
- `CLK`  input  1  system clock; all state updates on rising edge.
- `i_reset`  input  1  synchronous, active-high reset.
- `i_btn_n`  input  N_BTN  raw asynchronous buttons, active-low (0 = pressed).
- `o_btn_n`  output  N_BTN  debounced level, active-low.
- `o_press`  output  N_BTN  one-cycle high pulse per accepted press and per repeat event.
- `o_release`  output  N_BTN  one-cycle high pulse per accepted release.
- `o_step_n`  output  N_BTN  `~o_press`; one-cycle low pulse for negedge consumers.

## Operation
- Per channel, fully independent; simultaneous events on several channels produce simultaneous pulses.
- Sync: 2-FF synchronizer per bit, flops reset to 1 (released). `s2` = raw input delayed 2 cycles.
- Debounce: `stable` register (reset 1). Counter `db_cnt` clears whenever `s2 == stable`; increments while `s2 != stable`. When `s2 != stable` and `db_cnt == DEBOUNCE_CYC-1`, next edge: `stable <= s2`, `db_cnt <= 0`. Any glitch shorter than `DEBOUNCE_CYC` cycles is discarded.
- Edge events: on the cycle `stable` goes 1->0, `o_press` = 1; on 0->1, `o_release` = 1. All outputs registered; `o_btn_n` = `stable`.
- Repeat FSM (per channel) states: IDLE, DELAY, REPEAT.
  - IDLE -> DELAY on accepted press; `rp_cnt <= 0`.
  - DELAY: `rp_cnt` counts; at `REPEAT_DELAY_CYC-1` emit `o_press` pulse next cycle, go REPEAT, clear `rp_cnt`.
  - REPEAT: at `REPEAT_RATE_CYC-1` emit pulse, clear `rp_cnt`, stay.
  - Any state -> IDLE on accepted release; no press pulse in the release cycle; pending repeat discarded.
- Press pulse timing: accepted press at cycle P; repeats at P+REPEAT_DELAY_CYC, then every REPEAT_RATE_CYC.

## Timing
- Reset values: `o_btn_n` all 1, `o_press` 0, `o_release` 0, `o_step_n` all 1, `stable` 1, sync flops 1, counters 0, FSM IDLE.
- Latency raw edge -> `o_press`/`o_btn_n` change: 2 + `DEBOUNCE_CYC` cycles, given a raw level held constant throughout.
- Same latency for release -> `o_release`.
- Pulses exactly one cycle wide; minimum spacing between press pulses on one channel is `REPEAT_RATE_CYC` (>= 1 cycle gap guaranteed only for REPEAT_RATE_CYC >= 2; default satisfies this).
- Reset mid-press: all state cleared; a key still held after reset deassertion is treated as a new press (full 2 + `DEBOUNCE_CYC` latency, then `o_press`).
- Reset has priority over every event in the same cycle.

## Configuration
- `BTN_AUTOREPEAT_EN` defined: repeat FSM and `rp_cnt` compiled in as above.
- Not defined: repeat logic removed; exactly one `o_press` pulse per accepted press; `REPEAT_*` parameters ignored.

## Test plan
Bench parameters: `N_BTN`=3, `DEBOUNCE_CYC`=4, `REPEAT_DELAY_CYC`=10, `REPEAT_RATE_CYC`=3.
- Clean press of ch0 at cycle 0, held 8 cycles -> `o_btn_n[0]` falls and single `o_press[0]`/`o_step_n[0]` pulse at cycle 6; release -> `o_release[0]` 6 cycles after raw rise.
- Bounce: ch1 toggled low/high every 2 cycles for 20 cycles, then high -> no output change, no pulses.
- Auto-repeat (macro on): ch2 held 30 cycles -> press pulses at P, P+10, P+13, P+16, P+19, ... until release; none after release accepted; macro off -> only P.
- Simultaneous: ch0 and ch1 pressed same cycle -> both `o_press` bits pulse in same cycle.
- Reset mid-hold: ch0 held, `i_reset` high for 2 cycles at P+5 -> outputs return to reset values; with key still held, new press pulse 6 cycles after reset deasserts.

Source files
------------

// File: rtl/button_conditioner.sv
// button_conditioner: synchronizes, debounces and edge-detects active-low
// push-buttons, producing clean one-cycle press/release events per channel.
// Each press pulse also appears as a one-cycle low on o_step_n, so a
// negedge-triggered consumer sees exactly one falling edge per event.
// Optional feature macro: BTN_AUTOREPEAT_EN. When it is defined, a held key
// produces repeat press events after REPEAT_DELAY_CYC cycles and then every
// REPEAT_RATE_CYC cycles. Without the macro, one press pulse is produced
// per accepted press and the REPEAT_* parameters are only range-checked.
module button_conditioner #(
  parameter int N_BTN            = 3,
  parameter int DEBOUNCE_CYC     = 500000,
  parameter int REPEAT_DELAY_CYC = 25000000,
  parameter int REPEAT_RATE_CYC  = 5000000,
  parameter int CNT_W            = 26
) (
  input  logic             CLK,
  input  logic             i_reset,
  input  logic [N_BTN-1:0] i_btn_n,
  output logic [N_BTN-1:0] o_btn_n,
  output logic [N_BTN-1:0] o_press,
  output logic [N_BTN-1:0] o_release,
  output logic [N_BTN-1:0] o_step_n
);

  // Elaboration-time guard: every cycle parameter must be at least 1, and
  // its terminal count must fit in the per-channel counters.
  if ((DEBOUNCE_CYC < 1) || (REPEAT_DELAY_CYC < 1) || (REPEAT_RATE_CYC < 1) ||
      (64'(DEBOUNCE_CYC) > (64'd1 << CNT_W)) ||
      (64'(REPEAT_DELAY_CYC) > (64'd1 << CNT_W)) ||
      (64'(REPEAT_RATE_CYC) > (64'd1 << CNT_W))) begin : g_bad_params
    $error("button_conditioner: cycle parameters out of range for CNT_W");
  end

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYC - 1);

  logic [N_BTN-1:0] r_sync1;
  logic [N_BTN-1:0] r_sync2;

  // Two-flop synchronizer for all raw key inputs; idles at "released".
  always_ff @(posedge CLK) begin
    if (i_reset) begin
      r_sync1 <= '1;
      r_sync2 <= '1;
    end else begin
      r_sync1 <= i_btn_n;
      r_sync2 <= r_sync1;
    end
  end

  for (genvar g = 0; g < N_BTN; g++) begin : g_ch
    logic             r_stable;
    logic [CNT_W-1:0] r_db_cnt;
    logic             r_press;
    logic             r_release;
    logic             r_step_n;
    logic             w_diff;
    logic             w_accept;
    logic             w_press_acc;
    logic             w_release_acc;
    logic             w_repeat;

    // A level change is accepted once the synchronized input has differed
    // from the stable level for DEBOUNCE_CYC consecutive cycles.
    assign w_diff        = (r_sync2[g] != r_stable);
    assign w_accept      = w_diff && (r_db_cnt == DB_LAST);
    assign w_press_acc   = w_accept && !r_sync2[g];
    assign w_release_acc = w_accept &&  r_sync2[g];

    // Debounce counter and accepted level; any disagreement shorter than
    // the debounce window clears the counter and is discarded.
    always_ff @(posedge CLK) begin
      if (i_reset) begin
        r_stable <= 1'b1;
        r_db_cnt <= '0;
      end else if (!w_diff) begin
        r_db_cnt <= '0;
      end else if (w_accept) begin
        r_stable <= r_sync2[g];
        r_db_cnt <= '0;
      end else begin
        r_db_cnt <= r_db_cnt + CNT_W'(1);
      end
    end

`ifdef BTN_AUTOREPEAT_EN
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_DELAY  = 2'd1;
    localparam logic [1:0] S_REPEAT = 2'd2;

    localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(REPEAT_DELAY_CYC - 1);
    localparam logic [CNT_W-1:0] RR_LAST = CNT_W'(REPEAT_RATE_CYC - 1);

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_rp_cnt;

    // A repeat fires at the terminal count of the current wait, unless the
    // key is released on that same edge, which cancels it.
    assign w_repeat = !w_release_acc &&
                      (((r_state == S_DELAY)  && (r_rp_cnt == RD_LAST)) ||
                       ((r_state == S_REPEAT) && (r_rp_cnt == RR_LAST)));

    // Auto-repeat sequencer: initial delay after a press, then a fixed
    // rate until the release is accepted.
    always_ff @(posedge CLK) begin
      if (i_reset) begin
        r_state  <= S_IDLE;
        r_rp_cnt <= '0;
      end else if (w_release_acc) begin
        r_state  <= S_IDLE;
        r_rp_cnt <= '0;
      end else if (w_press_acc) begin
        r_state  <= S_DELAY;
        r_rp_cnt <= '0;
      end else begin
        case (r_state)
          S_DELAY: begin
            if (r_rp_cnt == RD_LAST) begin
              r_state  <= S_REPEAT;
              r_rp_cnt <= '0;
            end else begin
              r_rp_cnt <= r_rp_cnt + CNT_W'(1);
            end
          end
          S_REPEAT: begin
            if (r_rp_cnt == RR_LAST) begin
              r_rp_cnt <= '0;
            end else begin
              r_rp_cnt <= r_rp_cnt + CNT_W'(1);
            end
          end
          default: begin
            r_state  <= S_IDLE;
            r_rp_cnt <= '0;
          end
        endcase
      end
    end
`else
    assign w_repeat = 1'b0;
`endif

    // Registered event outputs; the step output is kept as its own flop so
    // that downstream negedge logic sees a glitch-free signal.
    always_ff @(posedge CLK) begin
      if (i_reset) begin
        r_press   <= 1'b0;
        r_release <= 1'b0;
        r_step_n  <= 1'b1;
      end else begin
        r_press   <= w_press_acc | w_repeat;
        r_release <= w_release_acc;
        r_step_n  <= ~(w_press_acc | w_repeat);
      end
    end

    assign o_btn_n[g]   = r_stable;
    assign o_press[g]   = r_press;
    assign o_release[g] = r_release;
    assign o_step_n[g]  = r_step_n;
  end

endmodule
